// File: rtl/ustawianie_pkg.sv
// Shared types for the bit-range setter: FSM state encoding and default width.
package ustawianie_pkg;

  localparam int BITS_DEF = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } state_t;

endpackage

// File: rtl/ustawienie_bitu.sv
// Combinational single step: OR a one-hot bit at position idx into acc.
module ustawienie_bitu #(
  parameter int BITS  = 32,
  parameter int CNT_W = $clog2(BITS) + 1
) (
  input  logic [BITS-1:0]  acc,
  input  logic [CNT_W-1:0] idx,
  output logic [BITS-1:0]  res
);

  logic [BITS-1:0] one;

  assign one = {{(BITS-1){1'b0}}, 1'b1};
  assign res = acc | (one << idx);

endmodule

// File: rtl/sterownik_ustawiania.sv
// Sets i_count consecutive bits of A starting at bit B, one bit per cycle.
// Optional USTAWIANIE_ABORT_EN adds i_abort to cancel a running operation.
module sterownik_ustawiania
  import ustawianie_pkg::*;
#(
  parameter int BITS = BITS_DEF,
  localparam int CNT_W = $clog2(BITS) + 1
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_start,
  input  logic signed [BITS-1:0] i_arg_A,
  input  logic signed [BITS-1:0] i_arg_B,
  input  logic [CNT_W-1:0]       i_count,
`ifdef USTAWIANIE_ABORT_EN
  input  logic                   i_abort,
`endif
  output logic signed [BITS-1:0] o_result,
  output logic                   o_busy,
  output logic                   o_done,
  output logic                   o_error
);

  localparam logic signed [BITS-1:0] MAX_IDX = BITS'(BITS - 1);
  localparam logic [BITS:0]          LIM     = (BITS + 1)'(BITS);

  state_t           state;
  logic [BITS-1:0]  acc;
  logic [BITS-1:0]  acc_nxt;
  logic [CNT_W-1:0] idx;
  logic [CNT_W-1:0] rem;
  logic [BITS:0]    sum;
  logic             bad;
  logic             abort;

`ifdef USTAWIANIE_ABORT_EN
  assign abort = i_abort;
`else
  assign abort = 1'b0;
`endif

  // Range end is checked unsigned one bit wider so B+count cannot wrap
  assign sum = {1'b0, i_arg_B}
             + {{(BITS + 1 - CNT_W){1'b0}}, i_count};
  assign bad = i_arg_B[BITS-1]
            || (i_arg_B > MAX_IDX && i_count != '0)
            || (sum > LIM);

  ustawienie_bitu #(
    .BITS  (BITS),
    .CNT_W (CNT_W)
  ) u_bit (
    .acc (acc),
    .idx (idx),
    .res (acc_nxt)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state    <= IDLE;
      acc      <= '0;
      idx      <= '0;
      rem      <= '0;
      o_result <= '0;
      o_busy   <= 1'b0;
      o_done   <= 1'b0;
      o_error  <= 1'b0;
    end else begin
      o_done  <= 1'b0;
      o_error <= 1'b0;
      unique case (state)
        IDLE: begin
          if (i_start) begin
            acc <= i_arg_A;
            idx <= i_arg_B[CNT_W-1:0];
            rem <= i_count;
            if (bad) begin
              state <= ERR;
            end else if (i_count == '0) begin
              state <= DONE;
            end else begin
              state  <= RUN;
              o_busy <= 1'b1;
            end
          end
        end
        RUN: begin
          if (abort) begin
            state  <= IDLE;
            o_busy <= 1'b0;
          end else begin
            acc <= acc_nxt;
            idx <= idx + 1'b1;
            rem <= rem - 1'b1;
            if (rem == CNT_W'(1)) begin
              state  <= DONE;
              o_busy <= 1'b0;
            end
          end
        end
        DONE: begin
          o_result <= acc;
          o_done   <= 1'b1;
          state    <= IDLE;
        end
        ERR: begin
          o_done  <= 1'b1;
          o_error <= 1'b1;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sterownik_ustawiania.sv
// Directed self-checking bench for sterownik_ustawiania (BITS=32).
module tb_sterownik_ustawiania;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic signed [31:0] arg_a;
  logic signed [31:0] arg_b;
  logic [5:0]         count;
`ifdef USTAWIANIE_ABORT_EN
  logic               abort;
`endif
  logic signed [31:0] result;
  logic               busy;
  logic               done;
  logic               error;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sterownik_ustawiania #(.BITS(32)) dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_start  (start),
    .i_arg_A  (arg_a),
    .i_arg_B  (arg_b),
    .i_count  (count),
`ifdef USTAWIANIE_ABORT_EN
    .i_abort  (abort),
`endif
    .o_result (result),
    .o_busy   (busy),
    .o_done   (done),
    .o_error  (error)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start one operation and follow it to o_done (bounded wait)
  task automatic op(input string tag, input logic [31:0] a,
                    input logic [31:0] b, input logic [5:0] n,
                    input logic exp_err, input logic [31:0] exp_res,
                    input int exp_lat, input int exp_busy,
                    input logic repulse);
    logic [31:0] prev;
    int lat;
    int nbusy;
    logic stable;
    prev   = result;
    start  = 1'b1;
    arg_a  = a;
    arg_b  = b;
    count  = n;
    tick();
    start  = 1'b0;
    lat    = 0;
    nbusy  = 0;
    stable = 1'b1;
    while (!done && lat < 40) begin
      if (busy) nbusy++;
      if (result !== prev) stable = 1'b0;
      if (repulse && lat == 0) begin
        start = 1'b1;
        arg_a = 32'h0;
        arg_b = 32'sd0;
        count = 6'd1;
      end else begin
        start = 1'b0;
      end
      tick();
      lat++;
    end
    start = 1'b0;
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_busy"}, nbusy, exp_busy);
    check({tag, "_stable"}, {31'd0, stable}, 32'd1);
    check({tag, "_done"}, {31'd0, done}, 32'd1);
    check({tag, "_err"}, {31'd0, error}, {31'd0, exp_err});
    check({tag, "_res"}, result, exp_res);
    tick();
    check({tag, "_pulse"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    arg_a = '0;
    arg_b = '0;
    count = '0;
`ifdef USTAWIANIE_ABORT_EN
    abort = 1'b0;
`endif
    #1;
    check("rst_res", result, 32'h0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_err", {31'd0, error}, 32'd0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    op("b4n3", 32'h0, 32'sd4, 6'd3, 1'b0, 32'h0000_0070, 4, 3, 1'b0);
    op("n0", 32'h0000_000F, 32'sd0, 6'd0, 1'b0, 32'h0000_000F, 1, 0, 1'b0);
    op("bneg", 32'h1234_5678, -32'sd1, 6'd2, 1'b1, 32'h0000_000F,
       1, 0, 1'b0);
    op("b30n3", 32'h0, 32'sd30, 6'd3, 1'b1, 32'h0000_000F, 1, 0, 1'b0);
    op("b29n3", 32'h0, 32'sd29, 6'd3, 1'b0, 32'hE000_0000, 4, 3, 1'b0);
    op("n33", 32'h0, 32'sd0, 6'd33, 1'b1, 32'hE000_0000, 1, 0, 1'b0);
    op("overlap", 32'h0000_00FF, 32'sd2, 6'd4, 1'b0, 32'h0000_00FF,
       5, 4, 1'b0);
    op("b31n1", 32'h0, 32'sd31, 6'd1, 1'b0, 32'h8000_0000, 2, 1, 1'b0);
    op("repulse", 32'h0, 32'sd8, 6'd4, 1'b0, 32'h0000_0F00, 5, 4, 1'b1);
    tick();
    tick();
    check("repulse_idle", {30'd0, busy, done}, 32'd0);

    start = 1'b1;
    arg_a = 32'h0;
    arg_b = 32'sd0;
    count = 6'd5;
    tick();
    start = 1'b0;
    tick();
    check("mid_busy", {31'd0, busy}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("arst_res", result, 32'h0);
    check("arst_flags", {29'd0, busy, done, error}, 32'd0);
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("arst_nodone", {31'd0, done}, 32'd0);
    end
    op("after_rst", 32'h0, 32'sd1, 6'd1, 1'b0, 32'h0000_0002, 2, 1, 1'b0);

`ifdef USTAWIANIE_ABORT_EN
    start = 1'b1;
    arg_a = 32'h0;
    arg_b = 32'sd3;
    count = 6'd4;
    tick();
    start = 1'b0;
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_busy", {31'd0, busy}, 32'd0);
    for (int i = 0; i < 6; i++) begin
      tick();
      check("abort_nodone", {31'd0, done}, 32'd0);
    end
    check("abort_res", result, 32'h0000_0002);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
